// File: rtl/pic_pkg.sv
// pic_pkg: shared types, constants and priority helpers for the PIC interrupt sequencer
package pic_pkg;

    localparam int NUM_IR = 8;

    typedef enum logic [1:0] {IDLE, REQ, ACK1} state_t;

    // Lowest index wins because IR0 is the highest priority level
    function automatic logic [2:0] lowest_set(input logic [NUM_IR-1:0] v);
        lowest_set = 3'd0;
        for (int i = NUM_IR - 1; i >= 0; i--)
            if (v[i]) lowest_set = 3'(i);
    endfunction

    function automatic logic [NUM_IR-1:0] one_hot(input logic [2:0] l);
        one_hot = 8'd1 << l;
    endfunction

    // Levels strictly above the highest-priority in-service level; all levels when nothing is in service
    function automatic logic [NUM_IR-1:0] priority_mask(input logic [NUM_IR-1:0] isr);
        priority_mask = (isr == '0) ? '1 : one_hot(lowest_set(isr)) - 8'd1;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver: combinational winner selection of unmasked requests against the in-service ceiling
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [7:0] req,
    input  logic [7:0] mask,
    input  logic [7:0] isr,
    output logic       winner_valid,
    output logic [2:0] winner_level,
    output logic [7:0] ceiling
);

    logic [7:0] serviceable;

    assign ceiling      = priority_mask(isr);
    assign serviceable  = req & ~mask & ceiling;
    assign winner_valid = |serviceable;
    assign winner_level = lowest_set(serviceable);

endmodule

// File: rtl/pic_int_sequencer.sv
// pic_int_sequencer: 8259 INT/INTA sequencing, in-service tracking, vector generation and EOI handling
module pic_int_sequencer
    import pic_pkg::*;
#(
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irr_in,
    input  logic [7:0] imr,
    input  logic       inta,
    input  logic       eoi,
    input  logic       aeoi,
    input  logic [4:0] vector_base,
    output logic       int_out,
    output logic [7:0] isr,
    output logic [7:0] irr_clear,
    output logic [7:0] vector,
    output logic       vector_valid
);

    state_t     state, state_n;
    logic       eval_q, eval_n;
    logic [2:0] lvl_q, lvl_n;
    logic       spur_q, spur_n;
    logic [7:0] isr_n, irr_clear_n, vector_n, eoi_clr;
    logic       vector_valid_n;
    logic       winner_valid;
    logic [2:0] winner_level;
    logic [7:0] ceiling;

    pic_priority_resolver u_resolver (
        .req          (irr_in),
        .mask         (imr),
        .isr          (isr),
        .winner_valid (winner_valid),
        .winner_level (winner_level),
        .ceiling      (ceiling)
    );

    // The ceiling sits just below the highest-priority in-service bit, so +1 is that bit
    assign eoi_clr = (eoi && isr != '0) ? ceiling + 8'd1 : 8'd0;
    assign int_out = (state == REQ);

    always_comb begin
        state_n        = state;
        eval_n         = 1'b0;
        lvl_n          = lvl_q;
        spur_n         = spur_q;
        isr_n          = isr & ~eoi_clr;
        irr_clear_n    = 8'd0;
        vector_n       = vector;
        vector_valid_n = 1'b0;
        case (state)
            IDLE: begin
                eval_n  = winner_valid;
                state_n = (eval_q && winner_valid) ? REQ : IDLE;
            end
            REQ: if (inta) begin
                state_n     = ACK1;
                lvl_n       = winner_valid ? winner_level : SPURIOUS_LEVEL;
                spur_n      = !winner_valid;
                isr_n       = winner_valid ? isr_n | one_hot(winner_level) : isr_n;
                irr_clear_n = winner_valid ? one_hot(winner_level) : 8'd0;
            end
            ACK1: if (inta) begin
                state_n        = IDLE;
                vector_n       = {vector_base, lvl_q};
                vector_valid_n = 1'b1;
                isr_n          = (aeoi && !spur_q) ? isr_n & ~one_hot(lvl_q) : isr_n;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            eval_q       <= 1'b0;
            lvl_q        <= 3'd0;
            spur_q       <= 1'b0;
            isr          <= 8'd0;
            irr_clear    <= 8'd0;
            vector       <= 8'd0;
            vector_valid <= 1'b0;
        end else begin
            state        <= state_n;
            eval_q       <= eval_n;
            lvl_q        <= lvl_n;
            spur_q       <= spur_n;
            isr          <= isr_n;
            irr_clear    <= irr_clear_n;
            vector       <= vector_n;
            vector_valid <= vector_valid_n;
        end
    end

endmodule
